pipelined_barrel_shifter: RTL and testbench



---
 rtl/pipelined_barrel_shifter.sv | 122 ++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROL), one power-of-two step per stage, largest first.
// Define SHIFTER_ROTATE_EN to make op 2'b11 a rotate-left; otherwise it behaves as SLL.
module pipelined_barrel_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int TAG_W   = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);

   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   logic [WIDTH-1:0]   data_q  [SHAMT_W];
   logic [WIDTH-1:0]   data_d  [SHAMT_W];
   logic [1:0]         op_q    [SHAMT_W];
   logic [1:0]         op_d    [SHAMT_W];
   logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
   logic [SHAMT_W-1:0] shamt_d [SHAMT_W];
   logic [TAG_W-1:0]   tag_q   [SHAMT_W];
   logic [TAG_W-1:0]   tag_d   [SHAMT_W];
   logic               sign_q  [SHAMT_W];
   logic               sign_d  [SHAMT_W];
   logic [SHAMT_W-1:0] vld_q;
   logic [SHAMT_W-1:0] vld_d;

   logic [WIDTH-1:0]   src_data  [SHAMT_W];
   logic [1:0]         src_op    [SHAMT_W];
   logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
   logic [TAG_W-1:0]   src_tag   [SHAMT_W];
   logic               src_sign  [SHAMT_W];
   logic               src_vld   [SHAMT_W];
   logic               advance;

   // sign is the original operand MSB, so SRA fill does not depend on earlier stages
   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input logic             sign,
                                                   input int               amt);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SRL:  r = d >> amt;
         OP_SRA:  r = sign ? ((d >> amt) | ~({WIDTH{1'b1}} >> amt)) : (d >> amt);
`ifdef SHIFTER_ROTATE_EN
         2'b11:   r = (d << amt) | (d >> (WIDTH - amt));
`endif
         default: r = d << amt;
      endcase
      return r;
   endfunction

   assign advance   = out_ready || !vld_q[SHAMT_W-1];
   assign in_ready  = advance;
   assign out_valid = vld_q[SHAMT_W-1];
   assign out_data  = data_q[SHAMT_W-1];
   assign out_tag   = tag_q[SHAMT_W-1];

   always_comb begin
      src_data[0]  = in_data;
      src_op[0]    = in_op;
      src_shamt[0] = in_shamt;
      src_tag[0]   = in_tag;
      src_sign[0]  = in_data[WIDTH-1];
      src_vld[0]   = in_valid && advance;
      for (int k = 1; k < SHAMT_W; k++) begin
         src_data[k]  = data_q[k-1];
         src_op[k]    = op_q[k-1];
         src_shamt[k] = shamt_q[k-1];
         src_tag[k]   = tag_q[k-1];
         src_sign[k]  = sign_q[k-1];
         src_vld[k]   = vld_q[k-1];
      end
   end

   // remaining shamt is kept MSB-aligned: each stage consumes the top bit and shifts it out
   always_comb begin
      vld_d = '0;
      for (int k = 0; k < SHAMT_W; k++) begin
         data_d[k]  = shift_step(src_data[k], src_op[k], src_sign[k],
                                 src_shamt[k][SHAMT_W-1] ? (1 << (SHAMT_W - 1 - k)) : 0);
         shamt_d[k] = src_shamt[k] << 1;
         op_d[k]    = src_op[k];
         tag_d[k]   = src_tag[k];
         sign_d[k]  = src_sign[k];
         vld_d[k]   = src_vld[k];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         for (int k = 0; k < SHAMT_W; k++) begin
            data_q[k]  <= '0;
            op_q[k]    <= '0;
            shamt_q[k] <= '0;
            tag_q[k]   <= '0;
            sign_q[k]  <= 1'b0;
         end
      end else if (advance) begin
         vld_q <= vld_d;
         for (int k = 0; k < SHAMT_W; k++) begin
            data_q[k]  <= data_d[k];
            op_q[k]    <= op_d[k];
            shamt_q[k] <= shamt_d[k];
            tag_q[k]   <= tag_d[k];
            sign_q[k]  <= sign_d[k];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (default 32-bit, 5-stage build).
module tb_pipelined_barrel_shifter;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;
   localparam int TAG_W   = 5;
   localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;

   logic               clock;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [1:0]         in_op;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [TAG_W-1:0]   out_tag;

   int checks = 0;
   int errors = 0;

   pipelined_barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      in_valid = 1'b0;
      in_data  = '0;
      in_shamt = '0;
      in_op    = SLL;
      in_tag   = '0;
   endtask

   task automatic drive(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                        input logic [1:0] op, input logic [TAG_W-1:0] t);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_op    = op;
      in_tag   = t;
   endtask

   // Issue one op into an idle pipeline; lat counts edges from accept to first out_valid (inclusive).
   task automatic run_one(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                          input logic [1:0] op, input logic [TAG_W-1:0] t,
                          output logic [WIDTH-1:0] rd, output logic [TAG_W-1:0] rt,
                          output int lat);
      out_ready = 1'b1;
      drive(d, s, op, t);
      tick();
      idle_inputs();
      lat = 1;
      while (!out_valid && lat < 12) begin
         tick();
         lat++;
      end
      rd = out_data;
      rt = out_tag;
      tick();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      out_ready = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
      checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %h expected 00", out_tag); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_sll_latency;
      logic [WIDTH-1:0] rd;
      logic [TAG_W-1:0] rt;
      int lat;
      run_one(32'h8000_0001, 5'd4, SLL, 5'd3, rd, rt, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL sll_latency: got %0d expected 5", lat); end
      checks++; if (rd !== 32'h0000_0010) begin errors++; $display("FAIL sll_data: got %h expected 00000010", rd); end
      checks++; if (rt !== 5'd3) begin errors++; $display("FAIL sll_tag: got %0d expected 3", rt); end
   endtask

   task automatic test_shift_ops;
      logic [WIDTH-1:0]   vd [10] = '{32'hF000_0000, 32'hF000_0000, 32'h7000_0000, 32'h8000_0000, 32'h8000_0000,
                                      32'h8000_0001, 32'hDEAD_BEEF, 32'h1234_5679, 32'h8000_0000, 32'hA5A5_0000};
      logic [SHAMT_W-1:0] vs [10] = '{5'd8, 5'd8, 5'd8, 5'd31, 5'd31, 5'd0, 5'd0, 5'd31, 5'd17, 5'd12};
      logic [1:0]         vo [10] = '{SRA, SRL, SRA, SRA, SRL, SRA, SLL, SLL, SRA, SRA};
      logic [WIDTH-1:0]   ve [10] = '{32'hFFF0_0000, 32'h00F0_0000, 32'h0070_0000, 32'hFFFF_FFFF, 32'h0000_0001,
                                      32'h8000_0001, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_C000, 32'hFFFA_5A50};
      logic [WIDTH-1:0] rd;
      logic [TAG_W-1:0] rt;
      int lat;
      for (int i = 0; i < 10; i++) begin
         run_one(vd[i], vs[i], vo[i], TAG_W'(i + 1), rd, rt, lat);
         checks++; if (rd !== ve[i]) begin errors++; $display("FAIL shift_op_%0d_data: got %h expected %h", i, rd, ve[i]); end
         checks++; if (rt !== TAG_W'(i + 1)) begin errors++; $display("FAIL shift_op_%0d_tag: got %0d expected %0d", i, rt, i + 1); end
         checks++; if (lat !== 5) begin errors++; $display("FAIL shift_op_%0d_latency: got %0d expected 5", i, lat); end
      end
   endtask

   task automatic test_back_to_back;
      logic [SHAMT_W-1:0] sh  [6] = '{5'd0, 5'd1, 5'd2, 5'd15, 5'd16, 5'd31};
      logic [WIDTH-1:0]   exp [6] = '{32'h1, 32'h2, 32'h4, 32'h0000_8000, 32'h0001_0000, 32'h8000_0000};
      logic [WIDTH-1:0]   gd  [6];
      logic [TAG_W-1:0]   gt  [6];
      int                 gc  [6];
      int n = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i < 6) drive(32'h1, sh[i], SLL, TAG_W'(10 + i));
         else idle_inputs();
         tick();
         if (out_valid) begin
            if (n < 6) begin gd[n] = out_data; gt[n] = out_tag; gc[n] = i; end
            n++;
         end
      end
      checks++; if (n !== 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", n); end
      for (int j = 0; j < 6 && j < n; j++) begin
         checks++; if (gd[j] !== exp[j]) begin errors++; $display("FAIL b2b_%0d_data: got %h expected %h", j, gd[j], exp[j]); end
         checks++; if (gt[j] !== TAG_W'(10 + j)) begin errors++; $display("FAIL b2b_%0d_tag: got %0d expected %0d", j, gt[j], 10 + j); end
         checks++; if (gc[j] !== 4 + j) begin errors++; $display("FAIL b2b_%0d_cycle: got %0d expected %0d", j, gc[j], 4 + j); end
      end
   endtask

   task automatic test_stall;
      logic [WIDTH-1:0] gd [8];
      logic [TAG_W-1:0] gt [8];
      int n = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(32'h1, SHAMT_W'(i + 1), SLL, TAG_W'(20 + i));
         tick();
      end
      checks++; if (out_valid !== 1'b1 || out_tag !== 5'd20) begin
         errors++; $display("FAIL stall_fill: got valid %b tag %0d expected valid 1 tag 20", out_valid, out_tag); end
      drive(32'h1, 5'd6, SLL, 5'd25);
      out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
      for (int r = 0; r < 3; r++) begin
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid_%0d: got %b expected 1", r, out_valid); end
         checks++; if (out_data !== 32'h2 || out_tag !== 5'd20) begin
            errors++; $display("FAIL stall_hold_%0d: got %h/%0d expected 00000002/20", r, out_data, out_tag); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold_in_ready_%0d: got %b expected 0", r, in_ready); end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (out_valid && out_ready) begin
            if (n < 8) begin gd[n] = out_data; gt[n] = out_tag; end
            n++;
         end
         tick();
         if (i == 0) idle_inputs();
      end
      checks++; if (n !== 6) begin errors++; $display("FAIL stall_drain_count: got %0d expected 6", n); end
      for (int j = 0; j < 6 && j < n; j++) begin
         checks++; if (gd[j] !== (32'h2 << j)) begin errors++; $display("FAIL stall_drain_%0d_data: got %h expected %h", j, gd[j], 32'h2 << j); end
         checks++; if (gt[j] !== TAG_W'(20 + j)) begin errors++; $display("FAIL stall_drain_%0d_tag: got %0d expected %0d", j, gt[j], 20 + j); end
      end
   endtask

   task automatic test_reset_flush;
      logic [WIDTH-1:0] rd;
      logic [TAG_W-1:0] rt;
      int lat;
      int leaked = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(32'hFFFF_FFFF, 5'd1, SRL, TAG_W'(28 + i));
         tick();
      end
      drive(32'hFFFF_FFFF, 5'd1, SRL, 5'd31);
      reset = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_out_data: got %h expected 00000000", out_data); end
      checks++; if (out_tag !== '0) begin errors++; $display("FAIL flush_out_tag: got %0d expected 0", out_tag); end
      reset = 1'b0;
      idle_inputs();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) leaked++;
      end
      checks++; if (leaked !== 0) begin errors++; $display("FAIL flush_leak: got %0d results expected 0", leaked); end
      run_one(32'h1, 5'd3, SLL, 5'd9, rd, rt, lat);
      checks++; if (rd !== 32'h8 || rt !== 5'd9 || lat !== 5) begin
         errors++; $display("FAIL flush_recover: got %h/%0d/%0d expected 00000008/9/5", rd, rt, lat); end
   endtask

   task automatic test_rol;
      logic [WIDTH-1:0] rd;
      logic [TAG_W-1:0] rt;
      logic [WIDTH-1:0] e1, e4;
      int lat;
`ifdef SHIFTER_ROTATE_EN
      e1 = 32'h0000_0003;
      e4 = 32'h0000_0018;
`else
      e1 = 32'h0000_0002;
      e4 = 32'h0000_0010;
`endif
      run_one(32'h8000_0001, 5'd1, ROL, 5'd17, rd, rt, lat);
      checks++; if (rd !== e1 || rt !== 5'd17) begin errors++; $display("FAIL rol_1: got %h/%0d expected %h/17", rd, rt, e1); end
      run_one(32'h8000_0001, 5'd4, ROL, 5'd18, rd, rt, lat);
      checks++; if (rd !== e4 || rt !== 5'd18) begin errors++; $display("FAIL rol_4: got %h/%0d expected %h/18", rd, rt, e4); end
   endtask

   initial begin
      reset = 1'b1;
      out_ready = 1'b1;
      idle_inputs();
      test_reset();
      test_sll_latency();
      test_shift_ops();
      test_back_to_back();
      test_stall();
      test_reset_flush();
      test_rol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
